// File: rtl/seven_segment_scan.sv
// Multiplexed common-anode seven-segment driver: double-buffered BCD frame,
// programmable slot rate, anti-ghosting guard and optional leading-zero blanking.

module seven_segment_digit #(
  parameter bit LZ_EN = 1'b1
) (
  input  logic [3:0] bcd,
  input  logic       dp_req,
  input  logic       upper_zero,
  output logic [6:0] seg,
  output logic       dp_n
);
  logic [6:0] seg_dec;
  logic       blanked;

  always_comb begin
    seg_dec = 7'b1111111;
    case (bcd)
      4'd0: seg_dec = 7'b0000001;
      4'd1: seg_dec = 7'b1001111;
      4'd2: seg_dec = 7'b0010010;
      4'd3: seg_dec = 7'b0000110;
      4'd4: seg_dec = 7'b1001100;
      4'd5: seg_dec = 7'b0100100;
      4'd6: seg_dec = 7'b0100000;
      4'd7: seg_dec = 7'b0001111;
      4'd8: seg_dec = 7'b0000000;
      4'd9: seg_dec = 7'b0000100;
      default: seg_dec = 7'b1111111;
    endcase
  end

  // a leading zero hides its decimal point too
  assign blanked = LZ_EN && upper_zero && (bcd == 4'd0);
  assign seg     = blanked ? 7'b1111111 : seg_dec;
  assign dp_n    = blanked ? 1'b1 : ~dp_req;
endmodule

module seven_segment_scan #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD       = 2,
  parameter int LZ_BLANK    = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank_en,
  output logic [6:0]              led_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   an_out,
  output logic                    frame_start
);
  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = $clog2(NUM_DIGITS);

  logic [PW-1:0] presc;
  logic [IW-1:0] idx;
  logic          tick, last, xfer, in_guard;

  logic [NUM_DIGITS-1:0][3:0] shadow, active;
  logic [NUM_DIGITS-1:0]      dp_shadow, dp_active;

  logic [NUM_DIGITS-1:0][6:0] seg_all;
  logic [NUM_DIGITS-1:0]      dp_all;
  logic [NUM_DIGITS:1]        zchain;

  logic [6:0]            led_nxt;
  logic                  dp_nxt;
  logic [NUM_DIGITS-1:0] an_nxt;

  assign tick = (presc == PW'(REFRESH_DIV - 1));
  assign last = (idx == IW'(NUM_DIGITS - 1));
  assign xfer = tick && last;

  generate
    if (GUARD == 0) begin : g_noguard
      assign in_guard = 1'b0;
    end else begin : g_guard
      assign in_guard = (presc < PW'(GUARD));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc <= '0;
      idx   <= '0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (tick) idx <= last ? '0 : idx + 1'b1;
    end
  end

  // a load on the transfer edge bypasses the shadow so it is not lost a frame
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow    <= '0;
      dp_shadow <= '0;
      active    <= '0;
      dp_active <= '0;
    end else begin
      if (load) begin
        shadow    <= digits_in;
        dp_shadow <= dp_in;
      end
      if (xfer) begin
        active    <= load ? digits_in : shadow;
        dp_active <= load ? dp_in : dp_shadow;
      end
    end
  end

  // zchain[k]: digit k and every digit above it are zero
  assign zchain[NUM_DIGITS] = 1'b1;

  generate
    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_dig
      if (k > 0) begin : g_z
        assign zchain[k] = zchain[k+1] && (active[k] == 4'd0);
      end
      seven_segment_digit #(
        .LZ_EN((LZ_BLANK != 0) && (k != 0))
      ) u_dig (
        .bcd       (active[k]),
        .dp_req    (dp_active[k]),
        .upper_zero(zchain[k+1]),
        .seg       (seg_all[k]),
        .dp_n      (dp_all[k])
      );
    end
  endgenerate

  always_comb begin
    led_nxt = 7'b1111111;
    dp_nxt  = 1'b1;
    an_nxt  = '1;
    if (!blank_en && !in_guard) begin
      an_nxt  = ~(NUM_DIGITS'(1) << idx);
      led_nxt = seg_all[idx];
      dp_nxt  = dp_all[idx];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      led_out     <= 7'b1111111;
      dp_out      <= 1'b1;
      an_out      <= '1;
      frame_start <= 1'b0;
    end else begin
      led_out     <= led_nxt;
      dp_out      <= dp_nxt;
      an_out      <= an_nxt;
      frame_start <= xfer;
    end
  end
endmodule

// File: tb/tb_seven_segment_scan.sv
// Directed bench for seven_segment_scan: 4 digits, 4-cycle slots, 1-cycle guard;
// a second instance runs with leading-zero blanking disabled.

module tb_seven_segment_scan;
  logic        clk, rst, load, blank_en;
  logic [15:0] digits_in;
  logic [3:0]  dp_in;
  logic [6:0]  led_out, led0;
  logic        dp_out, dp0, fs, fs0;
  logic [3:0]  an_out, an0;

  int checks = 0;
  int failures = 0;

  logic [11:0] cap  [16];
  logic [11:0] cap0 [16];
  logic [15:0] cap_fs;

  localparam logic [6:0] S0 = 7'b0000001, S1 = 7'b1001111, S2 = 7'b0010010,
                         S3 = 7'b0000110, S4 = 7'b1001100, S5 = 7'b0100100,
                         S7 = 7'b0001111, S9 = 7'b0000100, SB = 7'b1111111;

  seven_segment_scan #(.NUM_DIGITS(4), .REFRESH_DIV(4), .GUARD(1), .LZ_BLANK(1)) dut (
    .clk(clk), .rst(rst), .load(load), .digits_in(digits_in), .dp_in(dp_in),
    .blank_en(blank_en), .led_out(led_out), .dp_out(dp_out), .an_out(an_out),
    .frame_start(fs));

  seven_segment_scan #(.NUM_DIGITS(4), .REFRESH_DIV(4), .GUARD(1), .LZ_BLANK(0)) dut0 (
    .clk(clk), .rst(rst), .load(load), .digits_in(digits_in), .dp_in(dp_in),
    .blank_en(blank_en), .led_out(led0), .dp_out(dp0), .an_out(an0),
    .frame_start(fs0));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  // expected {an, led, dp} for the k-th cycle after frame_start
  function automatic logic [11:0] exp_word(input int k, input logic [27:0] el, input logic [3:0] ed);
    int s;
    s = k / 4;
    if (k % 4 == 0) return 12'hFFF;
    return {~(4'b0001 << s), el[7*s +: 7], ed[s]};
  endfunction

  task automatic capture(input bit sync);
    int w;
    if (sync) begin
      @(negedge clk);
      w = 0;
      while (fs !== 1'b1 && w < 64) begin
        @(negedge clk);
        w++;
      end
      checks++;
      if (fs !== 1'b1) begin
        failures++;
        $display("FAIL capture_sync frame_start=%b required 1 within 64 cycles", fs);
      end
    end
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      cap[k]    = {an_out, led_out, dp_out};
      cap0[k]   = {an0, led0, dp0};
      cap_fs[k] = fs;
    end
  endtask

  task automatic load_word(input logic [15:0] d, input logic [3:0] p);
    load = 1'b1; digits_in = d; dp_in = p;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; load = 1'b0; blank_en = 1'b0; digits_in = '0; dp_in = '0;
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({an_out, led_out, dp_out, fs} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL reset_lz got an=%b led=%b dp=%b fs=%b required 1111 1111111 1 0", an_out, led_out, dp_out, fs);
    end
    checks++;
    if ({an0, led0, dp0, fs0} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL reset_nolz got an=%b led=%b dp=%b fs=%b required 1111 1111111 1 0", an0, led0, dp0, fs0);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_idle;
    int n;
    logic [27:0] el;
    n = 0;
    while (fs !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != 16) begin
      failures++;
      $display("FAIL idle_first_frame got %0d cycles required 16", n);
    end
    capture(0);
    el = {SB, SB, SB, S0};
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (cap[k] !== exp_word(k, el, 4'hF)) begin
        failures++;
        $display("FAIL idle_lz k=%0d got %b required %b", k, cap[k], exp_word(k, el, 4'hF));
      end
      checks++;
      if (cap0[k] !== exp_word(k, {4{S0}}, 4'hF)) begin
        failures++;
        $display("FAIL idle_nolz k=%0d got %b required %b", k, cap0[k], exp_word(k, {4{S0}}, 4'hF));
      end
    end
    checks++;
    if (cap_fs !== 16'h8000) begin
      failures++;
      $display("FAIL idle_fs_period got %b required %b", cap_fs, 16'h8000);
    end
  endtask

  task automatic test_load_1234;
    logic [27:0] el;
    @(negedge clk);
    load_word(16'h1234, 4'b0100);
    capture(1);
    el = {S1, S2, S3, S4};
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (cap[k] !== exp_word(k, el, 4'b1011)) begin
        failures++;
        $display("FAIL load1234 k=%0d got %b required %b", k, cap[k], exp_word(k, el, 4'b1011));
      end
    end
  endtask

  task automatic test_lz_0070;
    logic [27:0] el, el0;
    @(negedge clk);
    load_word(16'h0070, 4'b1000);
    capture(1);
    el  = {SB, SB, S7, S0};
    el0 = {S0, S0, S7, S0};
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (cap[k] !== exp_word(k, el, 4'hF)) begin
        failures++;
        $display("FAIL lz0070 k=%0d got %b required %b", k, cap[k], exp_word(k, el, 4'hF));
      end
      checks++;
      if (cap0[k] !== exp_word(k, el0, 4'b0111)) begin
        failures++;
        $display("FAIL nolz0070 k=%0d got %b required %b", k, cap0[k], exp_word(k, el0, 4'b0111));
      end
    end
  endtask

  task automatic test_codes_f0a9;
    logic [27:0] el;
    @(negedge clk);
    load_word(16'hF0A9, 4'b0000);
    capture(1);
    el = {SB, S0, SB, S9};
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (cap[k] !== exp_word(k, el, 4'hF)) begin
        failures++;
        $display("FAIL codesF0A9 k=%0d got %b required %b", k, cap[k], exp_word(k, el, 4'hF));
      end
    end
  endtask

  // starts on a frame_start cycle; loads 5555 so it lands on the next transfer edge
  task automatic test_back_to_back;
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk);
      if (n == 2) begin load = 1'b1; digits_in = 16'h1111; dp_in = '0; end
      if (n == 3) load = 1'b0;
      if (n == 15) begin load = 1'b1; digits_in = 16'h5555; end
      if (n == 16) load = 1'b0;
    end
    checks++;
    if (fs !== 1'b1) begin
      failures++;
      $display("FAIL b2b_transfer_fs got %b required 1", fs);
    end
    fork
      capture(0);
      begin
        @(negedge clk);
        @(negedge clk);
        load = 1'b1; digits_in = 16'h2222;
        @(negedge clk);
        load = 1'b0;
      end
    join
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (cap[k] !== exp_word(k, {4{S5}}, 4'hF)) begin
        failures++;
        $display("FAIL bypass5555 k=%0d got %b required %b", k, cap[k], exp_word(k, {4{S5}}, 4'hF));
      end
    end
    capture(0);
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (cap[k] !== exp_word(k, {4{S2}}, 4'hF)) begin
        failures++;
        $display("FAIL next2222 k=%0d got %b required %b", k, cap[k], exp_word(k, {4{S2}}, 4'hF));
      end
    end
  endtask

  // starts on a frame_start cycle with 2222 active
  task automatic test_blank_reset;
    int n;
    blank_en = 1'b1;
    for (int i = 1; i <= 26; i++) begin
      @(negedge clk);
      if (i <= 10) begin
        checks++;
        if ({an_out, led_out, dp_out} !== 12'hFFF) begin
          failures++;
          $display("FAIL blank_en i=%0d got %b required %b", i, {an_out, led_out, dp_out}, 12'hFFF);
        end
        if (i == 10) blank_en = 1'b0;
      end
      if (i == 12 || i == 26) begin
        checks++;
        if ({an_out, led_out, dp_out} !== {4'b1011, S2, 1'b1}) begin
          failures++;
          $display("FAIL slot2_show i=%0d got %b required %b", i, {an_out, led_out, dp_out}, {4'b1011, S2, 1'b1});
        end
      end
      if (i == 16) begin
        checks++;
        if (fs !== 1'b1) begin
          failures++;
          $display("FAIL blank_fs_period got %b required 1", fs);
        end
      end
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({an_out, led_out, dp_out, fs} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL midframe_reset got %b required %b", {an_out, led_out, dp_out, fs}, {4'hF, 7'h7F, 1'b1, 1'b0});
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (n == 2) begin
        checks++;
        if ({an_out, led_out, dp_out} !== {4'b1110, S0, 1'b1}) begin
          failures++;
          $display("FAIL restart_slot0 got %b required %b", {an_out, led_out, dp_out}, {4'b1110, S0, 1'b1});
        end
      end
      if (fs === 1'b1) break;
    end
    checks++;
    if (n != 16) begin
      failures++;
      $display("FAIL restart_first_frame got %0d cycles required 16", n);
    end
    capture(0);
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (cap[k] !== exp_word(k, {SB, SB, SB, S0}, 4'hF)) begin
        failures++;
        $display("FAIL restart_frame k=%0d got %b required %b", k, cap[k], exp_word(k, {SB, SB, SB, S0}, 4'hF));
      end
    end
  endtask

  initial begin
    test_reset;
    test_idle;
    test_load_1234;
    test_lz_0070;
    test_codes_f0a9;
    test_back_to_back;
    test_blank_reset;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
